data_mem_lsu: RTL and testbench

- Parametrised data memory with an integrated load/store unit for the RISC-V core's MEM stage.
- Generalises the plain word-addressed data memory in three ways:
  - byte-addressed requests with byte/half/word/(double) sizes;
  - sign/zero extension on loads, with misalign and range error reporting;
  - registered one-cycle read, a valid/ready request handshake, and a post-reset memory clear sequence.
- Sits between the MEM-stage pipeline register and write-back.

---
 rtl/data_mem_lsu.sv | 215 +++++++++++++++++++++
 tb/tb_data_mem_lsu.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: byte-addressed data memory with an integrated load/store
// unit for the MEM stage. Requests take one cycle and responses are
// registered. After reset the memory can be zeroed one word per cycle
// before requests are accepted.
module data_mem_lsu #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int NB  = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int IDX = $clog2(DEPTH);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t            state_q, state_d;
  logic [IDX-1:0]    clr_cnt_q, clr_cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              ld_q, ld_d;
  logic [1:0]        ld_size_q, ld_size_d;
  logic              ld_uns_q, ld_uns_d;
  logic [OFF-1:0]    ld_off_q, ld_off_d;
  logic [IDX-1:0]    rd_idx_d;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [IDX-1:0]    mem_idx;
  logic [NB-1:0]     mem_be;
  logic [DATA_W-1:0] mem_wdata;

  // Request decode
  logic [IDX-1:0]    req_idx;
  logic [OFF-1:0]    lane_off;
  logic [3:0]        size_bytes;
  logic              err_range;
  logic              err_align;
  logic              err_size;
  logic              req_err;
  logic [NB-1:0]     be_base;
  logic [DATA_W-1:0] wmask;
  logic [NB-1:0]     be_shift;
  logic [DATA_W-1:0] wdata_shift;

  assign req_idx    = req_addr[OFF +: IDX];
  assign lane_off   = req_addr[OFF-1:0];
  assign size_bytes = 4'd1 << req_size;
  // size_bytes-1 gives the low address bits that must be zero; for a
  // double (8 bytes) the low three bits wrap to 3'b111 as required.
  assign err_align  = |(req_addr[2:0] & (size_bytes[2:0] - 3'd1));
  assign err_size   = (req_size == 2'b11) && (DATA_W != 64);
  assign req_err    = err_range | err_align | err_size;

  generate
    if (ADDR_W > OFF + IDX) begin : g_range
      assign err_range = |req_addr[ADDR_W-1:OFF+IDX];
    end else begin : g_no_range
      assign err_range = 1'b0;
    end
  endgenerate

  // Per-lane enables of the right-aligned store data before lane shifting
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign be_base[gi]          = (4'(gi) < size_bytes);
      assign wmask[gi*8 +: 8]     = {8{be_base[gi]}};
    end
  endgenerate

  assign be_shift    = be_base << lane_off;
  assign wdata_shift = (req_wdata & wmask) << {lane_off, 3'b000};

  // Next-state, clear sequencing, write control and response capture
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    mem_we      = 1'b0;
    mem_idx     = req_idx;
    mem_be      = be_shift;
    mem_wdata   = wdata_shift;
    rd_idx_d    = req_idx;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    ld_d        = 1'b0;
    ld_size_d   = req_size;
    ld_uns_d    = req_unsigned;
    ld_off_d    = lane_off;
    req_ready   = 1'b0;
    busy        = 1'b0;
    case (state_q)
      CLEAR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_idx   = clr_cnt_q;
        mem_be    = '1;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == IDX'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        req_ready = 1'b1;
        if (req_valid) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = req_err;
          ld_d        = ~req_we & ~req_err;
          mem_we      = req_we & ~req_err;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
    // A reset cycle must not disturb memory; the clear restarts afterwards
    if (RST) begin
      mem_we = 1'b0;
    end
  end

  // Control and response registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      ld_q        <= 1'b0;
      ld_size_q   <= 2'b00;
      ld_uns_q    <= 1'b0;
      ld_off_q    <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      ld_q        <= ld_d;
      ld_size_q   <= ld_size_d;
      ld_uns_q    <= ld_uns_d;
      ld_off_q    <= ld_off_d;
    end
  end

  // Memory array: byte-enabled write and registered read on the same edge
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_be[b]) begin
          mem[mem_idx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
      end
    end
    rd_data_q <= mem[rd_idx_d];
  end

  // Load data alignment and extension
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] ext_byte;
  logic [DATA_W-1:0] ext_half;
  logic [DATA_W-1:0] ext_word;
  logic [DATA_W-1:0] ext_data;

  assign rd_shift = rd_data_q >> {ld_off_q, 3'b000};
  assign ext_byte = ld_uns_q ? {{(DATA_W-8){1'b0}}, rd_shift[7:0]}
                             : {{(DATA_W-8){rd_shift[7]}}, rd_shift[7:0]};
  assign ext_half = ld_uns_q ? {{(DATA_W-16){1'b0}}, rd_shift[15:0]}
                             : {{(DATA_W-16){rd_shift[15]}}, rd_shift[15:0]};

  generate
    if (DATA_W == 64) begin : g_word64
      assign ext_word = ld_uns_q ? {32'b0, rd_shift[31:0]}
                                 : {{32{rd_shift[31]}}, rd_shift[31:0]};
    end else begin : g_word32
      assign ext_word = rd_shift;
    end
  endgenerate

  // Select the extended lane by the captured size
  always_comb begin
    ext_data = rd_shift;
    case (ld_size_q)
      2'b00:   ext_data = ext_byte;
      2'b01:   ext_data = ext_half;
      2'b10:   ext_data = ext_word;
      default: ext_data = rd_shift;
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = (rsp_valid_q & ld_q) ? ext_data : '0;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu (DATA_W=32, DEPTH=16) with a byte-array model.
module tb_data_mem_lsu;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] ref_mem [64];

  data_mem_lsu #(
    .DATA_W(32), .DEPTH(16), .ADDR_W(32), .CLEAR_ON_RESET(1)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Reference: error rule from byte address and size
  function automatic logic model_err(input logic [1:0] size, input logic [31:0] addr);
    int n;
    n = 1 << size;
    return (addr >= 32'd64) || (size == 2'b11) || ((addr % n) != 0);
  endfunction

  // Reference: little-endian assembled load with extension
  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr);
    logic [63:0] v;
    int n;
    if (model_err(size, addr)) return 32'h0;
    n = 1 << size;
    v = 64'h0;
    for (int i = 0; i < n; i++) v = v | (64'(ref_mem[int'(addr) + i]) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v[31:0];
  endfunction

  task automatic model_store(input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata);
    int n;
    if (model_err(size, addr)) return;
    n = 1 << size;
    for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = 8'(wdata >> (8 * i));
  endtask

  // Drive one request for one accepting edge and capture its response
  task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic v, output logic e, output logic [31:0] d);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    @(posedge CLK);
    #1;
    v = rsp_valid;
    e = rsp_err;
    d = rsp_rdata;
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    int bad_ready;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    n_checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ctl: busy=%b ready=%b, want busy=1 ready=0", busy, req_ready);
    end
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_rsp: valid=%b err=%b rdata=%h, want 0/0/0", rsp_valid, rsp_err, rsp_rdata);
    end
    cnt = 0;
    bad_ready = 0;
    while (busy === 1'b1 && cnt < 100) begin
      if (req_ready !== 1'b0) bad_ready++;
      cnt++;
      @(posedge CLK);
      #1;
    end
    n_checks++;
    if (cnt !== 16 || bad_ready !== 0) begin
      n_errors++;
      $display("FAIL clear_len: busy cycles=%0d ready_high=%0d, want 16/0", cnt, bad_ready);
    end
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL run_ready: req_ready=%b, want 1", req_ready);
    end
    $display("reset: clear lasted %0d cycles", cnt);
  endtask

  task automatic test_clear_readback();
    logic v, e;
    logic [31:0] d;
    for (int a = 0; a < 64; a += 4) begin
      do_op(1'b0, 2'b10, 1'b0, 32'(a), 32'h0, v, e, d);
      n_checks++;
      if (v !== 1'b1 || e !== 1'b0 || d !== 32'h0) begin
        n_errors++;
        $display("FAIL clear_read @%h: v=%b e=%b d=%h, want 1/0/0", a, v, e, d);
      end
    end
    $display("clear readback: 16 words checked");
  endtask

  task automatic test_word_byte();
    logic v, e;
    logic [31:0] d;
    do_op(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, v, e, d);
    model_store(2'b10, 32'h8, 32'hDEADBEEF);
    n_checks++;
    if (v !== 1'b1 || e !== 1'b0 || d !== 32'h0) begin
      n_errors++;
      $display("FAIL st_word: v=%b e=%b d=%h, want 1/0/0", v, e, d);
    end
    do_op(1'b1, 2'b00, 1'b0, 32'h9, 32'h80, v, e, d);
    model_store(2'b00, 32'h9, 32'h80);
    do_op(1'b0, 2'b00, 1'b0, 32'h9, 32'h0, v, e, d);
    n_checks++;
    if (v !== 1'b1 || e !== 1'b0 || d !== 32'hFFFFFF80) begin
      n_errors++;
      $display("FAIL lb_signed: v=%b e=%b d=%h, want 1/0/ffffff80", v, e, d);
    end
    do_op(1'b0, 2'b00, 1'b1, 32'h9, 32'h0, v, e, d);
    n_checks++;
    if (d !== 32'h00000080 || e !== 1'b0) begin
      n_errors++;
      $display("FAIL lb_unsigned: d=%h e=%b, want 00000080/0", d, e);
    end
    do_op(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, v, e, d);
    n_checks++;
    if (d !== 32'hDEAD80EF || e !== 1'b0) begin
      n_errors++;
      $display("FAIL lw_merged: d=%h e=%b, want dead80ef/0", d, e);
    end
    $display("word/byte: word @8 = %h", d);
  endtask

  task automatic test_half();
    logic v, e;
    logic [31:0] d;
    do_op(1'b1, 2'b01, 1'b0, 32'h6, 32'h8001, v, e, d);
    model_store(2'b01, 32'h6, 32'h8001);
    do_op(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, v, e, d);
    n_checks++;
    if (d !== 32'hFFFF8001 || e !== 1'b0) begin
      n_errors++;
      $display("FAIL lh_signed: d=%h e=%b, want ffff8001/0", d, e);
    end
    do_op(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, v, e, d);
    n_checks++;
    if (d !== 32'h00008001 || e !== 1'b0) begin
      n_errors++;
      $display("FAIL lh_unsigned: d=%h e=%b, want 00008001/0", d, e);
    end
    do_op(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, v, e, d);
    n_checks++;
    if (d[31:16] !== 16'h8001 || d !== model_load(2'b10, 1'b0, 32'h4)) begin
      n_errors++;
      $display("FAIL lw_half: d=%h, want upper 8001 and %h", d, model_load(2'b10, 1'b0, 32'h4));
    end
    $display("half: word @4 = %h", d);
  endtask

  task automatic test_errors();
    logic v, e;
    logic [31:0] d;
    do_op(1'b0, 2'b01, 1'b0, 32'h1, 32'h0, v, e, d);
    n_checks++;
    if (v !== 1'b1 || e !== 1'b1 || d !== 32'h0) begin
      n_errors++;
      $display("FAIL err_lh_mis: v=%b e=%b d=%h, want 1/1/0", v, e, d);
    end
    do_op(1'b1, 2'b10, 1'b0, 32'h2, 32'h12345678, v, e, d);
    n_checks++;
    if (v !== 1'b1 || e !== 1'b1) begin
      n_errors++;
      $display("FAIL err_sw_mis: v=%b e=%b, want 1/1", v, e);
    end
    do_op(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, v, e, d);
    n_checks++;
    if (d !== model_load(2'b10, 1'b0, 32'h0) || e !== 1'b0) begin
      n_errors++;
      $display("FAIL err_unchanged: word0=%h, want %h", d, model_load(2'b10, 1'b0, 32'h0));
    end
    do_op(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, v, e, d);
    n_checks++;
    if (v !== 1'b1 || e !== 1'b1 || d !== 32'h0) begin
      n_errors++;
      $display("FAIL err_range: v=%b e=%b d=%h, want 1/1/0", v, e, d);
    end
    do_op(1'b0, 2'b11, 1'b0, 32'h8, 32'h0, v, e, d);
    n_checks++;
    if (v !== 1'b1 || e !== 1'b1 || d !== 32'h0) begin
      n_errors++;
      $display("FAIL err_size: v=%b e=%b d=%h, want 1/1/0", v, e, d);
    end
    do_op(1'b1, 2'b11, 1'b0, 32'h8, 32'h0, v, e, d);
    do_op(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, v, e, d);
    n_checks++;
    if (d !== model_load(2'b10, 1'b0, 32'h8)) begin
      n_errors++;
      $display("FAIL err_size_st: word8=%h, want %h", d, model_load(2'b10, 1'b0, 32'h8));
    end
    $display("errors: misalign/range/size cases done");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      req_valid    = 1'b1;
      req_we       = (i % 2 == 0);
      req_size     = 2'b10;
      req_unsigned = 1'b0;
      req_addr     = 32'h10;
      req_wdata    = 32'(i / 2 + 1);
      if (req_we) model_store(2'b10, 32'h10, 32'(i / 2 + 1));
      @(posedge CLK);
      #1;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 ||
          rsp_rdata !== ((i % 2 == 1) ? 32'(i / 2 + 1) : 32'h0)) begin
        n_errors++;
        $display("FAIL stream[%0d]: v=%b e=%b d=%h, want 1/0/%h", i, rsp_valid, rsp_err,
                 rsp_rdata, (i % 2 == 1) ? 32'(i / 2 + 1) : 32'h0);
      end
    end
    req_valid = 1'b0;
    req_we    = 1'b0;
    @(posedge CLK);
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL stream_idle: rsp_valid=%b, want 0", rsp_valid);
    end
    $display("back_to_back: 8 streamed requests");
  endtask

  task automatic test_random();
    logic v, e;
    logic [31:0] d;
    logic        we, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata, exp_d;
    logic        exp_e;
    for (int i = 0; i < 300; i++) begin
      we    = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr  = 32'($urandom_range(0, 71));
      if ($urandom_range(0, 15) == 0) addr = addr | (32'h100 << $urandom_range(0, 20));
      wdata = $urandom;
      exp_e = model_err(size, addr);
      exp_d = we ? 32'h0 : model_load(size, uns, addr);
      do_op(we, size, uns, addr, wdata, v, e, d);
      if (we) model_store(size, addr, wdata);
      n_checks++;
      if (v !== 1'b1 || e !== exp_e || d !== exp_d) begin
        n_errors++;
        $display("FAIL rand[%0d] we=%b sz=%0d u=%b a=%h: v=%b e=%b d=%h, want 1/%b/%h",
                 i, we, size, uns, addr, v, e, d, exp_e, exp_d);
      end
    end
    $display("random: 300 requests");
  endtask

  task automatic test_reset_midstream();
    logic v, e;
    logic [31:0] d;
    int cnt;
    int pulses;
    do_op(1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A51234, v, e, d);
    model_store(2'b10, 32'h20, 32'hA5A51234);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_size  = 2'b10;
    req_addr  = 32'h20;
    RST       = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_reset: rsp_valid=%b busy=%b, want 0/1", rsp_valid, busy);
    end
    req_we    = 1'b1;
    req_wdata = 32'hFFFFFFFF;
    cnt = 0;
    pulses = 0;
    while (busy === 1'b1 && cnt < 100) begin
      if (rsp_valid !== 1'b0) pulses++;
      cnt++;
      @(posedge CLK);
      #1;
    end
    req_valid = 1'b0;
    req_we    = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    n_checks++;
    if (cnt !== 16 || pulses !== 0) begin
      n_errors++;
      $display("FAIL mid_clear: busy cycles=%0d pulses=%0d, want 16/0", cnt, pulses);
    end
    do_op(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, v, e, d);
    n_checks++;
    if (v !== 1'b1 || e !== 1'b0 || d !== model_load(2'b10, 1'b0, 32'h20)) begin
      n_errors++;
      $display("FAIL mid_cleared: v=%b e=%b d=%h, want 1/0/0", v, e, d);
    end
    $display("reset mid-stream: clear %0d cycles, word @20 = %h", cnt, d);
  endtask

  initial begin
    RST          = 1'b1;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    test_reset();
    test_clear_readback();
    test_word_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
